// File: rtl/sprite_line_renderer.sv
// Renders up to 8 16x16 one-colour sprites into a double-buffered 640-pixel line buffer.
// Colour for column c appears 2 cycles after hcount=2c; host writes take no wait states, no backpressure.
module sprite_line_renderer #(
    parameter int NSPRITES = 8,
    parameter int HTOTAL   = 1600,
    parameter int VTOTAL   = 525
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        chipselect,
    input  logic        write,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [6:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAW  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [9:0]          sh_x   [NSPRITES];
    logic [8:0]          sh_y   [NSPRITES];
    logic [2:0]          sh_c   [NSPRITES];
    logic [NSPRITES-1:0] sh_en;
    logic [23:0]         sh_pal [NSPRITES];
    logic [9:0]          act_x   [NSPRITES];
    logic [8:0]          act_y   [NSPRITES];
    logic [2:0]          act_c   [NSPRITES];
    logic [NSPRITES-1:0] act_en;
    logic [23:0]         act_pal [NSPRITES];
    logic                frame_ok;

    logic        copy;
    logic        unused_bits;
    assign copy        = (hcount == 11'(HTOTAL - 1)) && (vcount == 10'(VTOTAL - 1));
    assign unused_bits = ^writedata[31:23];

    // A write landing on the copy cycle reaches only the shadow, since the copy samples old shadows.
    always_ff @(posedge clk50) begin
        if (reset) begin
            for (int k = 0; k < NSPRITES; k++) begin
                sh_x[k]    <= '0;
                sh_y[k]    <= '0;
                sh_c[k]    <= '0;
                sh_pal[k]  <= '0;
                act_x[k]   <= '0;
                act_y[k]   <= '0;
                act_c[k]   <= '0;
                act_pal[k] <= '0;
            end
            sh_en    <= '0;
            act_en   <= '0;
            frame_ok <= 1'b0;
        end else begin
            if (chipselect && write) begin
                if (!address[3]) begin
                    sh_x[address[2:0]]  <= writedata[9:0];
                    sh_y[address[2:0]]  <= writedata[18:10];
                    sh_c[address[2:0]]  <= writedata[21:19];
                    sh_en[address[2:0]] <= writedata[22];
                end else begin
                    sh_pal[address[2:0]] <= writedata[23:0];
                end
            end
            if (copy) begin
                act_x    <= sh_x;
                act_y    <= sh_y;
                act_c    <= sh_c;
                act_en   <= sh_en;
                act_pal  <= sh_pal;
                frame_ok <= 1'b1;
            end
        end
    end

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [3:0]  col;
    logic [15:0] pat;
    logic [9:0]  t;
    logic [9:0]  dy;
    logic        hit;
    logic        render_go;
    logic [10:0] draw_x;
    logic        draw_we;

    assign t         = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    assign render_go = (hcount == 11'd0) && (t <= 10'd479);
    assign dy        = t - {1'b0, act_y[idx]};
    assign hit       = act_en[idx] && (dy < 10'd16);
    assign draw_x    = {1'b0, act_x[idx]} + {7'd0, col};
    assign draw_we   = (state == S_DRAW) && pat[4'd15 - col] && (draw_x <= 11'd639)
                       && (act_c[idx] != 3'd0);

    // Slots are visited 7 down to 0 so the lowest slot is painted last and wins overlaps.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            col      <= '0;
            pat      <= '0;
            rom_addr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (render_go) begin
                        state <= S_CHECK;
                        idx   <= 3'd7;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        rom_addr <= {idx, dy[3:0]};
                        state    <= S_FETCH;
                    end else if (idx == 3'd0) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    pat   <= rom_data;
                    col   <= '0;
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    col <= col + 4'd1;
                    if (col == 4'd15) begin
                        if (idx == 3'd0) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx - 3'd1;
                            state <= S_CHECK;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [2:0] buf_a [0:639];
    logic [2:0] buf_b [0:639];
    logic       disp_sel;
    logic [9:0] pcol;
    logic       active;
    logic       clr_we;
    logic       act_d;
    logic [2:0] rd_idx;

    assign pcol   = hcount[10:1];
    assign active = (hcount < 11'd1280) && (vcount < 10'd480);
    assign clr_we = active && hcount[0];

    // Display side zeroes each entry right after reading it, so a buffer is blank when it becomes the render target.
    always_ff @(posedge clk50) begin
        if (!reset) begin
            if (disp_sel) begin
                if (draw_we) buf_a[draw_x[9:0]] <= act_c[idx];
                if (clr_we)  buf_b[pcol] <= 3'd0;
            end else begin
                if (draw_we) buf_b[draw_x[9:0]] <= act_c[idx];
                if (clr_we)  buf_a[pcol] <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            disp_sel              <= 1'b0;
            act_d                 <= 1'b0;
            rd_idx                <= '0;
            {VGA_R, VGA_G, VGA_B} <= 24'd0;
        end else begin
            if (hcount == 11'(HTOTAL - 1)) disp_sel <= ~disp_sel;
            act_d <= active;
            if (active && !hcount[0]) rd_idx <= disp_sel ? buf_b[pcol] : buf_a[pcol];
            {VGA_R, VGA_G, VGA_B} <= (act_d && frame_ok) ? act_pal[rd_idx] : 24'd0;
        end
    end

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Pixel-generation stage directly downstream of the VGA timing counters: consumes `hcount`/`vcount` and produces 24-bit RGB for the 640x480 raster. Draws up to 8 single-colour 16x16 bitmap sprites over a programmable background. Uses a double-buffered line buffer: the next line is rendered while the current line is displayed. Sprite positions and palette are written by the host over a simple register-write port and take effect at frame boundaries.

## Interface
- `NSPRITES`, 8: number of sprite slots; fixed at 8, since the address map depends on it.
- `HTOTAL`, 1600: clk50 cycles per line.
- `VTOTAL`, 525: lines per frame.
- `clk50  in  1`: system clock, 50 MHz.
- `reset  in  1`: one clock; reset is synchronous and active-high.
- `hcount  in  11`: horizontal count, 0..1599; `hcount[10:1]` is the pixel column.
- `vcount  in  10`: line count, 0..524.
- `chipselect  in  1`, `write  in  1`: a host write occurs when both are high.
- `address  in  4`: 0-7 selects a sprite slot; 8-15 selects palette entries 0-7.
- `writedata  in  32`: sprite word or palette word.
- `rom_addr  out  7`: pattern ROM address, `{sprite[2:0], row[3:0]}`.
- `rom_data  in  16`: pattern row; bit 15 is the leftmost pixel; data is valid 1 cycle after `rom_addr`.
- `VGA_R`, `VGA_G`, `VGA_B`  `out  8` each: registered colour outputs.

## Operation
- Sprite word: `[9:0]` x, `[18:10]` y, `[21:19]` colour index, `[22]` enable.
- Palette word: `[23:0]` RGB. Index 0 is the background; index 0 is never drawn by sprites.
- Host writes go to shadow registers.
  - All shadows copy to the active set on the cycle `hcount==HTOTAL-1 && vcount==VTOTAL-1`.
  - If a write coincides with the copy cycle, the new value lands in the shadow only and takes effect next frame.
- Line buffers: two 640x3-bit buffers, A and B.
  - The buffer roles swap at every `hcount==HTOTAL-1`.
- Render target line: `t = (vcount==VTOTAL-1) ? 0 : vcount+1`. Rendering runs only when `t <= 479`.
- Render FSM, starting at `hcount==0`:
  - IDLE -> CHECK, with i = 7.
  - CHECK:
    - Goes to FETCH if slot i is enabled and `0 <= t - y <= 15`. The subtraction is 10-bit unsigned; an underflow counts as a miss.
    - Otherwise decrements i; CHECK after i = 0 goes to DONE.
  - FETCH: drives `rom_addr = {i, t-y}` for 1 cycle, then goes to WAIT.
  - WAIT: captures `rom_data`, then goes to DRAW.
  - DRAW: 16 cycles, col = 0..15.
    - Writes the colour index at `x+col` when bit `15-col` is 1 and `x+col <= 639` (computed at 11 bits, so no wrap).
    - Pixels off the right edge are clipped.
    - Then decrements i and returns to CHECK (or DONE).
  - DONE: holds until the next `hcount==0`.
  - Slot 7 is drawn first and slot 0 last, so the lower slot number wins on overlap.
  - Worst case is 8 x 19 = 152 cycles, which is far less than 1600. The FSM is always in DONE before the swap.
- Display side, for active pixels:
  - On even `hcount < 1280`: read display buffer entry `hcount[10:1]`.
  - On the following odd cycle: write 0 to that entry, so the buffer is clean for reuse.
  - Outside active video (`hcount >= 1280` or `vcount >= 480`): RGB = 0.
- After reset, `frame_ok` = 0 and RGB is forced to 0.
  - `frame_ok` is set at the first shadow-copy cycle.
  - Buffer contents are undefined until one full frame has cleared them; the forced-0 output covers that frame.

## Timing
- Reset values:
  - `VGA_R/G/B` = 0; `rom_addr` = 0; FSM = IDLE.
  - All active and shadow sprite enables = 0; palette = 0; buffer select = A.
- Reset asserted mid-render aborts the render immediately. No line-buffer writes occur while `reset` is high.
- Latency: colour for column c appears on the outputs during `hcount = 2c+2` and `2c+3` (read register, then palette register).
  - Downstream must delay HS/VS/BLANK by 2 clk50 cycles.
- Host write: 0 wait states. The shadow register updates on the cycle after the write.

## Test plan
- Reset, then one frame with no sprites enabled and palette[0] = 0x000080 -> every active pixel is 0x000080; RGB = 0 in blanking; RGB = 0 throughout the first frame after reset.
- Slot 0 at x=100, y=50, colour 1 (palette[1] = 0xFF0000), ROM row 0 = 0x8001 -> on line 50, columns 100 and 115 are 0xFF0000 and column 101 is background; lines 49 and 66 show no sprite.
- Slots 0 and 1 overlapping at the same x/y, colours 1 and 2 -> the overlapped pixels show the colour-1 value.
- Slot at x=630, ROM row = 0xFFFF -> columns 630-639 are coloured; no write beyond 639; the next line's column 0 is not corrupted.
- Host moves a sprite mid-frame at line 200 -> the current frame keeps the old position; the new position appears from line 0 of the next frame; a write on the copy cycle is delayed one frame.
- Reset asserted at `hcount=10` of line 100 and released, with sprites re-enabled -> outputs are 0 immediately, there is no garbage in the following frame, and correct rendering resumes after one full frame.
